// File: rtl/avg_div_feeder.sv
//==============================================================================
// Module  : avg_div_feeder
// Brief   : Accumulates a window of sensor samples, feeds sum/count to a
//           sequential divider and publishes the quotient as the average.
// Revision: 1.0
//==============================================================================
`default_nettype none

module avg_div_feeder #(
   parameter int W   = 8,
   parameter int N   = 16,
   parameter int TMO = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sample_in,
   input  logic         sample_valid,
   output logic         sample_ready,
   input  logic [7:0]   win_len,
   output logic [N-1:0] dividend,
   output logic [N-1:0] divisor,
   output logic         sen1,
   output logic         sen2,
   input  logic [N-1:0] q,
   input  logic         div_done,
   output logic [N-1:0] avg,
   output logic         avg_valid,
   output logic         overflow,
   output logic         err
);

   localparam int WDW = $clog2(TMO + 1);
   localparam logic [WDW-1:0] WD_ONE  = 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

   localparam logic [2:0] ST_ACCUM = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   logic [2:0]     state_q, state_d;
   logic [N-1:0]   sum_q, sum_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [7:0]     len_q, len_d;
   logic [N-1:0]   dividend_q, dividend_d;
   logic [N-1:0]   divisor_q, divisor_d;
   logic [N-1:0]   avg_q, avg_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           sen1_q, sen1_d;
   logic           sen2_q, sen2_d;
   logic           avg_valid_q, avg_valid_d;
   logic           overflow_q, overflow_d;
   logic           err_q, err_d;

   logic           w_first;
   logic [N-1:0]   w_base;
   logic [N:0]     w_sum_wide;
   logic           w_sat;
   logic [7:0]     w_len_eff;
   logic [7:0]     w_cnt_inc;

   assign sample_ready = (state_q == ST_ACCUM);

   // The first sample of a window restarts the sum rather than adding to it.
   assign w_first    = (cnt_q == 8'd0);
   assign w_base     = w_first ? '0 : sum_q;
   assign w_sum_wide = {1'b0, w_base} + {1'b0, N'(sample_in)};
   assign w_sat      = w_sum_wide[N];
   assign w_len_eff  = w_first ? ((win_len == 8'd0) ? 8'd1 : win_len) : len_q;
   assign w_cnt_inc  = cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      avg_d       = avg_q;
      wd_d        = wd_q;
      overflow_d  = overflow_q;
      sen1_d      = 1'b0;
      sen2_d      = 1'b0;
      avg_valid_d = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            if (sample_valid) begin
               sum_d      = w_sat ? '1 : w_sum_wide[N-1:0];
               overflow_d = (w_first ? 1'b0 : overflow_q) | w_sat;
               len_d      = w_len_eff;
               cnt_d      = w_cnt_inc;
               if (w_cnt_inc == w_len_eff) begin
                  state_d = ST_LOAD;
                  sen1_d  = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            dividend_d = sum_q;
            divisor_d  = N'(cnt_q);
            sen2_d     = 1'b1;
            state_d    = ST_START;
         end
         ST_START: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wd_d = wd_q + WD_ONE;
            if (div_done) begin
               avg_d       = q;
               avg_valid_d = 1'b1;
               state_d     = ST_OUT;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               sum_d   = '0;
               cnt_d   = 8'd0;
               state_d = ST_ACCUM;
            end
         end
         ST_OUT: begin
            sum_d   = '0;
            cnt_d   = 8'd0;
            state_d = ST_ACCUM;
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ACCUM;
         sum_q       <= '0;
         cnt_q       <= 8'd0;
         len_q       <= 8'd0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         avg_q       <= '0;
         wd_q        <= '0;
         sen1_q      <= 1'b0;
         sen2_q      <= 1'b0;
         avg_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         avg_q       <= avg_d;
         wd_q        <= wd_d;
         sen1_q      <= sen1_d;
         sen2_q      <= sen2_d;
         avg_valid_q <= avg_valid_d;
         overflow_q  <= overflow_d;
         err_q       <= err_d;
      end
   end

   assign dividend  = dividend_q;
   assign divisor   = divisor_q;
   assign avg       = avg_q;
   assign sen1      = sen1_q;
   assign sen2      = sen2_q;
   assign avg_valid = avg_valid_q;
   assign overflow  = overflow_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_avg_div_feeder.sv
//==============================================================================
// Module  : tb_avg_div_feeder
// Brief   : Randomised and directed bench for avg_div_feeder against a
//           window/timeline model, plus an 8-bit instance for saturation.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_avg_div_feeder;

   localparam int W   = 8;
   localparam int N   = 16;
   localparam int TMO = 64;
   localparam int SUM_MAX = (1 << N) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, sample_valid, sample_ready, sen1, sen2;
   logic         div_done, avg_valid, overflow, err;
   logic [W-1:0] sample_in;
   logic [7:0]   win_len;
   logic [N-1:0] dividend, divisor, q, avg;

   avg_div_feeder #(.W(W), .N(N), .TMO(TMO)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .win_len(win_len), .dividend(dividend),
      .divisor(divisor), .sen1(sen1), .sen2(sen2), .q(q), .div_done(div_done),
      .avg(avg), .avg_valid(avg_valid), .overflow(overflow), .err(err)
   );

   logic       r8, v8, rdy8, sen1_8, sen2_8, dd8, av8, ovf8, err8;
   logic [7:0] s8, wl8, dvd8, dvs8, q8, avg8;

   avg_div_feeder #(.W(8), .N(8), .TMO(64)) dut8 (
      .clk(clk), .reset(r8), .sample_in(s8), .sample_valid(v8),
      .sample_ready(rdy8), .win_len(wl8), .dividend(dvd8),
      .divisor(dvs8), .sen1(sen1_8), .sen2(sen2_8), .q(q8), .div_done(dd8),
      .avg(avg8), .avg_valid(av8), .overflow(ovf8), .err(err8)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: a window is "busy" from the cycle after its last sample; k counts
   // cycles since that sample (1 = arm pulse, 2 = start pulse, >=3 waiting).
   bit m_busy, m_out, m_err, m_ovf;
   int m_k, m_cnt, m_len, m_sum, m_done_at, m_avg, m_dvd, m_dvs;
   int next_lat;
   int q_next;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_out = 0; m_err = 0; m_ovf = 0;
      m_k = 0; m_cnt = 0; m_len = 0; m_sum = 0; m_done_at = -1;
      m_avg = 0; m_dvd = 0; m_dvs = 0;
   endtask

   task automatic compare();
      chk("sample_ready", sample_ready, !m_busy);
      chk("sen1", sen1, m_busy && !m_out && m_k == 1);
      chk("sen2", sen2, m_busy && !m_out && m_k == 2);
      chk("avg_valid", avg_valid, m_out);
      chk("err", err, m_err);
      chk("overflow", overflow, m_ovf);
      chk("avg", avg, m_avg);
      chk("dividend", dividend, m_dvd);
      chk("divisor", divisor, m_dvs);
   endtask

   // One clock: check outputs, drive inputs for the coming edge, advance model.
   task automatic step(input bit v, input int s, input int wl, input bit r);
      bit dd;
      int qv;
      @(negedge clk);
      cyc++;
      compare();
      if (m_busy && !m_out && m_k >= 3) dd = (m_k == m_done_at);
      else                              dd = ($urandom_range(0, 5) == 0);
      qv = (q_next >= 0) ? q_next : int'($urandom_range(0, SUM_MAX));
      reset        = r;
      sample_valid = v;
      sample_in    = s[W-1:0];
      win_len      = wl[7:0];
      div_done     = dd;
      q            = qv[N-1:0];
      m_err = 0;
      if (r) begin
         model_reset();
      end else if (!m_busy) begin
         if (v) begin
            if (m_cnt == 0) begin
               m_len = (wl[7:0] == 8'd0) ? 1 : int'(wl[7:0]);
               m_ovf = 0;
               m_sum = int'(s[W-1:0]);
            end else begin
               m_sum += int'(s[W-1:0]);
            end
            if (m_sum > SUM_MAX) begin
               m_sum = SUM_MAX;
               m_ovf = 1;
            end
            m_cnt++;
            if (m_cnt == m_len) begin
               m_busy    = 1;
               m_k       = 1;
               m_done_at = (next_lat < 0) ? -1 : 3 + next_lat;
            end
         end
      end else if (m_out) begin
         m_busy = 0; m_out = 0; m_cnt = 0; m_sum = 0;
      end else if (m_k >= 3) begin
         if (dd) begin
            m_avg = qv;
            m_out = 1;
         end else if (m_k - 3 == TMO - 1) begin
            m_err = 1; m_busy = 0; m_cnt = 0; m_sum = 0;
         end else begin
            m_k++;
         end
      end else begin
         if (m_k == 1) begin
            m_dvd = m_sum;
            m_dvs = m_cnt;
         end
         m_k++;
      end
   endtask

   int sq[$];

   task automatic feed(input int wl, input int gap);
      foreach (sq[i]) begin
         step(1, sq[i], wl, 0);
         if (i < sq.size() - 1)
            repeat (gap) step(0, int'($urandom_range(0, 255)), wl, 0);
      end
   endtask

   // Runs until the window publishes or times out; lat = cycles from sen1.
   task automatic wait_end(output bit got_av, output bit got_err, output int lat);
      int s1c;
      s1c = -1; got_av = 0; got_err = 0;
      for (int i = 0; i < 150 && !got_av && !got_err; i++) begin
         step(m_busy ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 0);
         if (sen1 && s1c < 0) s1c = cyc;
         if (avg_valid) got_av = 1;
         if (err) got_err = 1;
      end
      if (!got_av && !got_err) chk("wait_bound", 0, 1);
      lat = cyc - s1c;
   endtask

   bit got_av, got_err;
   int lat;

   initial begin
      reset = 1; sample_valid = 0; sample_in = '0; win_len = '0; div_done = 0; q = '0;
      r8 = 1; v8 = 0; s8 = '0; wl8 = '0; dd8 = 0; q8 = '0;
      model_reset();
      q_next = -1; next_lat = 0;
      repeat (2) @(posedge clk);
      step(0, 0, 0, 1);
      chk("rst_ready", sample_ready, 1);
      chk("rst_avg", avg, 0);
      chk("rst_dividend", dividend, 0);

      // Back-to-back window 10,20,30,40.
      sq = '{10, 20, 30, 40}; next_lat = 2; q_next = 25;
      feed(4, 0);
      wait_end(got_av, got_err, lat);
      chk("t1_av", got_av, 1);
      chk("t1_lat", lat, 5);
      chk("t1_dividend", dividend, 100);
      chk("t1_divisor", divisor, 4);
      chk("t1_avg", avg, 25);
      chk("t1_ovf", overflow, 0);

      // Same window with 3-cycle gaps.
      feed(4, 3);
      wait_end(got_av, got_err, lat);
      chk("t2_dividend", dividend, 100);
      chk("t2_divisor", divisor, 4);
      chk("t2_avg", avg, 25);

      // win_len 0 behaves as 1; samples during busy are dropped.
      sq = '{7}; next_lat = 4; q_next = 1234;
      feed(0, 0);
      wait_end(got_av, got_err, lat);
      chk("t3_dividend", dividend, 7);
      chk("t3_divisor", divisor, 1);
      chk("t3_avg", avg, 1234);

      // Divider never answers.
      sq = '{5, 6}; next_lat = -1; q_next = -1;
      feed(2, 0);
      wait_end(got_av, got_err, lat);
      chk("t4_err", got_err, 1);
      chk("t4_err_lat", lat, 66);
      chk("t4_ready", sample_ready, 1);
      chk("t4_avg", avg, 1234);
      repeat (6) step(0, 0, 2, 0);

      // Reset while waiting, then a clean 3,3,3 window.
      sq = '{1, 2}; next_lat = -1;
      feed(2, 0);
      for (int i = 0; i < 40 && !(m_busy && m_k >= 10); i++) step(0, 0, 2, 0);
      step(0, 0, 2, 1);
      step(0, 0, 3, 0);
      chk("t5_ready", sample_ready, 1);
      chk("t5_dividend", dividend, 0);
      chk("t5_avg", avg, 0);
      sq = '{3, 3, 3}; next_lat = 1;
      feed(3, 0);
      wait_end(got_av, got_err, lat);
      chk("t5_dividend2", dividend, 9);
      chk("t5_divisor2", divisor, 3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         next_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
              int'($urandom_range(0, 9)), $urandom_range(0, 499) == 0);
      end

      // Saturation on the 8-bit instance.
      @(negedge clk); r8 = 0;
      @(negedge clk);
      chk("n8_rst_ovf", ovf8, 0);
      chk("n8_rst_ready", rdy8, 1);
      v8 = 1; s8 = 8'd200; wl8 = 8'd2;
      @(negedge clk);
      chk("n8_ovf_first", ovf8, 0);
      s8 = 8'd100;
      @(negedge clk);
      chk("n8_sen1", sen1_8, 1);
      chk("n8_ovf", ovf8, 1);
      v8 = 0;
      @(negedge clk);
      chk("n8_sen2", sen2_8, 1);
      chk("n8_dividend", dvd8, 255);
      chk("n8_divisor", dvs8, 2);
      @(negedge clk);
      dd8 = 1; q8 = 8'd127;
      @(negedge clk);
      chk("n8_av", av8, 1);
      chk("n8_avg", avg8, 127);
      dd8 = 0;
      @(negedge clk);
      chk("n8_ready", rdy8, 1);
      chk("n8_ovf_hold", ovf8, 1);
      v8 = 1; s8 = 8'd5;
      @(negedge clk);
      chk("n8_ovf_clear", ovf8, 0);
      v8 = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
